seg7_date_readback: RTL and testbench

- Inverse of the date display path: watches the six active-low 7-segment buses driving the date display (YY/MM/DD, two digits each) and decodes the glyphs back to BCD.
- Applies a stability filter, then range-checks the date and reports it once per stable value.
- Sits beside the display driver as a self-check / readback monitor. Its results go to status logic or a scan register.

---
 rtl/seg7_date_readback.sv | 153 +++++++++++++++
 tb/tb_seg7_date_readback.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_date_readback.sv
// Readback monitor for the YY/MM/DD 7-segment date display: decodes the glyphs back to BCD,
// filters for stability and reports each stable date once. Define MONTH_LEN_CHECK_EN to enable the month-length check.
module seg7_date_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] year_T1,
  input  logic [6:0] year_T2,
  input  logic [6:0] month_T1,
  input  logic [6:0] month_T2,
  input  logic [6:0] day_T1,
  input  logic [6:0] day_T2,
  output logic [7:0] year_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] day_bcd,
  output logic       date_valid,
  output logic       date_err,
  output logic [5:0] digit_err
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {S_COUNT, S_HOLD} state_t;

  // Returns {undecodable, digit}; blank and garbage both decode to F.
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'b1000000: seg_dec = 5'h00;
      7'b1111001: seg_dec = 5'h01;
      7'b0100100: seg_dec = 5'h02;
      7'b0110000: seg_dec = 5'h03;
      7'b0011001: seg_dec = 5'h04;
      7'b0010010: seg_dec = 5'h05;
      7'b0000010: seg_dec = 5'h06;
      7'b1111000: seg_dec = 5'h07;
      7'b0000000: seg_dec = 5'h08;
      7'b0010000: seg_dec = 5'h09;
      default:    seg_dec = 5'h1F;
    endcase
  endfunction

  logic [41:0]      w_live;
  logic [41:0]      r_snap;
  logic             w_match;
  logic             w_all_blank;
  logic [5:0][3:0]  w_dig;
  logic [5:0]       w_derr;
  logic [7:0]       w_mon_bin;
  logic [7:0]       w_day_bin;
  logic             w_len_ok;
  logic             w_date_ok;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_fire;

  logic [7:0]       r_year_bcd, r_month_bcd, r_day_bcd;
  logic             r_date_valid, r_date_err;
  logic [5:0]       r_digit_err;

  // Digit 5 is year tens, digit 0 is day units, matching the digit_err bit order.
  assign w_live      = {year_T1, year_T2, month_T1, month_T2, day_T1, day_T2};
  assign w_match     = (w_live == r_snap);
  assign w_all_blank = (r_snap == {42{1'b1}});

  for (genvar gi = 0; gi < 6; gi++) begin : g_dec
    logic [4:0] w_d;
    assign w_d        = seg_dec(r_snap[gi*7 +: 7]);
    assign w_dig[gi]  = w_d[3:0];
    assign w_derr[gi] = w_d[4];
  end

  assign w_mon_bin = 8'(w_dig[3]) * 8'd10 + 8'(w_dig[2]);
  assign w_day_bin = 8'(w_dig[1]) * 8'd10 + 8'(w_dig[0]);

`ifdef MONTH_LEN_CHECK_EN
  logic [7:0] w_yr_bin;
  logic [7:0] w_mlen;
  assign w_yr_bin = 8'(w_dig[5]) * 8'd10 + 8'(w_dig[4]);
  always_comb begin
    case (w_mon_bin)
      8'd4, 8'd6, 8'd9, 8'd11: w_mlen = 8'd30;
      8'd2:                    w_mlen = (w_yr_bin[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 w_mlen = 8'd31;
    endcase
  end
  assign w_len_ok = (w_day_bin <= w_mlen);
`else
  assign w_len_ok = 1'b1;
`endif

  assign w_date_ok = (w_derr == 6'b0)
                   && (w_dig[3] <= 4'd1) && (w_dig[1] <= 4'd3)
                   && (w_mon_bin >= 8'd1) && (w_mon_bin <= 8'd12)
                   && (w_day_bin >= 8'd1) && (w_day_bin <= 8'd31)
                   && w_len_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    if (!w_match) begin
      w_cnt_nxt   = '0;
      w_state_nxt = S_COUNT;
    end else if (r_state == S_COUNT) begin
      if (r_cnt == LAST) begin
        w_state_nxt = S_HOLD;
        w_fire      = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap       <= {42{1'b1}};
      r_state      <= S_COUNT;
      r_cnt        <= '0;
      r_year_bcd   <= '0;
      r_month_bcd  <= '0;
      r_day_bcd    <= '0;
      r_date_valid <= 1'b0;
      r_date_err   <= 1'b0;
      r_digit_err  <= '0;
    end else begin
      r_snap       <= w_live;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_date_valid <= 1'b0;
      r_date_err   <= 1'b0;
      // An all-blank display is treated as "driver idle": consume the report silently.
      if (w_fire && !w_all_blank) begin
        r_year_bcd   <= {w_dig[5], w_dig[4]};
        r_month_bcd  <= {w_dig[3], w_dig[2]};
        r_day_bcd    <= {w_dig[1], w_dig[0]};
        r_digit_err  <= w_derr;
        r_date_valid <= w_date_ok;
        r_date_err   <= !w_date_ok;
      end
    end
  end

  assign year_bcd   = r_year_bcd;
  assign month_bcd  = r_month_bcd;
  assign day_bcd    = r_day_bcd;
  assign date_valid = r_date_valid;
  assign date_err   = r_date_err;
  assign digit_err  = r_digit_err;

endmodule

// File: tb/tb_seg7_date_readback.sv
// Bench for seg7_date_readback: directed and random dates against a date-rule reference model.
module tb_seg7_date_readback;

  localparam int SC  = 4;
  localparam int WIN = SC + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] year_T1 = 7'h7F, year_T2 = 7'h7F, month_T1 = 7'h7F, month_T2 = 7'h7F;
  logic [6:0] day_T1 = 7'h7F, day_T2 = 7'h7F;
  logic [7:0] year_bcd, month_bcd, day_bcd;
  logic       date_valid, date_err;
  logic [5:0] digit_err;

  seg7_date_readback #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .year_T1(year_T1), .year_T2(year_T2), .month_T1(month_T1), .month_T2(month_T2),
    .day_T1(day_T1), .day_T2(day_T2),
    .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
    .date_valid(date_valid), .date_err(date_err), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  logic [6:0] GL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] g [6];  // 0=year tens .. 5=day units

  // Model of the last reported outputs
  logic [7:0] my_y = 0, my_m = 0, my_d = 0;
  logic [5:0] my_de = 0;

  int nchk = 0, npass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_date(input int y, input int m, input int d);
    g[0] = GL[y / 10]; g[1] = GL[y % 10];
    g[2] = GL[m / 10]; g[3] = GL[m % 10];
    g[4] = GL[d / 10]; g[5] = GL[d % 10];
  endtask

  task automatic drive();
    year_T1 = g[0]; year_T2 = g[1]; month_T1 = g[2]; month_T2 = g[3]; day_T1 = g[4]; day_T2 = g[5];
  endtask

  function automatic logic [41:0] packg();
    return {g[0], g[1], g[2], g[3], g[4], g[5]};
  endfunction

  // Count pulses over n cycles where none are expected
  task automatic watch(input string tag, input int n);
    int np = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (date_valid || date_err) np++;
    end
    chk(tag, np, 0);
  endtask

  // Reference model applied to the current glyphs, then one observation window
  task automatic observe_case(input string tag);
    int dg[6]; bit de[6];
    int yr, mon, day, mlen;
    bit blank, ok;
    int np = 0, nboth = 0, idx = -1;
    logic v = 0, e = 0;
    logic [7:0] oy = 0, om = 0, od = 0;
    logic [5:0] ode = 0;
    blank = 1;
    for (int i = 0; i < 6; i++) begin
      dg[i] = 15; de[i] = 1;
      for (int k = 0; k < 10; k++) if (g[i] == GL[k]) begin dg[i] = k; de[i] = 0; end
      if (g[i] != 7'h7F) blank = 0;
    end
    yr = dg[0] * 10 + dg[1]; mon = dg[2] * 10 + dg[3]; day = dg[4] * 10 + dg[5];
    ok = !(de[0] | de[1] | de[2] | de[3] | de[4] | de[5])
         && mon >= 1 && mon <= 12 && day >= 1 && day <= 31 && dg[2] <= 1 && dg[4] <= 3;
`ifdef MONTH_LEN_CHECK_EN
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) mlen = 30;
    else if (mon == 2) mlen = (yr % 4 == 0) ? 29 : 28;
    else mlen = 31;
    if (day > mlen) ok = 0;
`else
    mlen = 31;
`endif
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      if (date_valid && date_err) nboth++;
      if (date_valid || date_err) begin
        np++;
        if (idx < 0) begin
          idx = i; v = date_valid; e = date_err;
          oy = year_bcd; om = month_bcd; od = day_bcd; ode = digit_err;
        end
      end
    end
    chk({tag, ".both"}, nboth, 0);
    if (!blank) begin
      my_y = 8'((dg[0] << 4) | dg[1]);
      my_m = 8'((dg[2] << 4) | dg[3]);
      my_d = 8'((dg[4] << 4) | dg[5]);
      my_de = {de[0], de[1], de[2], de[3], de[4], de[5]};
      chk({tag, ".npulse"}, np, 1);
      chk({tag, ".when"}, idx, SC);
      chk({tag, ".valid"}, v, ok);
      chk({tag, ".err"}, e, !ok);
      chk({tag, ".bcd"}, {oy, om, od}, {my_y, my_m, my_d});
      chk({tag, ".derr"}, ode, my_de);
    end else begin
      chk({tag, ".npulse"}, np, 0);
    end
    chk({tag, ".hold"}, {year_bcd, month_bcd, day_bcd, 2'b00, digit_err}, {my_y, my_m, my_d, 2'b00, my_de});
  endtask

  task automatic run_case(input string tag);
    drive();
    observe_case(tag);
  endtask

  initial begin
    logic [41:0] prev;
    for (int i = 0; i < 6; i++) g[i] = 7'h7F;
    repeat (2) @(negedge clk);
    chk("reset.out", {year_bcd, month_bcd, day_bcd, date_valid, date_err, digit_err}, 0);
    rst = 1'b0;

    // Blank display after reset: silent
    observe_case("blank");

    set_date(86, 8, 22);  run_case("d860822");
    watch("quiet20", 20);

    // One-cycle glitch on day units at count 2 restarts the filter
    set_date(80, 7, 26);  drive();
    watch("glitch.pre", 3);
    g[5] = 7'h79;         drive();
    watch("glitch.mid", 1);
    set_date(80, 7, 26);  run_case("glitch");

    set_date(80, 13, 5);  run_case("month13");
    set_date(80, 7, 16);  g[4] = 7'b1010101; run_case("badglyph");
    set_date(80, 0, 15);  run_case("month00");
    set_date(80, 12, 31); run_case("d801231");
    set_date(80, 1, 0);   run_case("day00");

    // Reset mid-count discards the count
    set_date(80, 8, 17);  drive();
    watch("rst.pre", 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    my_y = 0; my_m = 0; my_d = 0; my_de = 0;
    chk("rst.mid", {year_bcd, month_bcd, day_bcd, date_valid, date_err, digit_err}, 0);
    observe_case("rst.post");

    set_date(1, 2, 29);   run_case("feb29_01");
    set_date(4, 2, 29);   run_case("feb29_04");
    set_date(80, 4, 31);  run_case("apr31");
    set_date(0, 2, 29);   run_case("feb29_00");

    for (int n = 0; n < 20; n++) begin
      prev = {year_T1, year_T2, month_T1, month_T2, day_T1, day_T2};
      do begin
        set_date($urandom_range(0, 99), $urandom_range(0, 15), $urandom_range(0, 39));
        if ($urandom_range(0, 3) == 0) g[$urandom_range(0, 5)] = 7'($urandom);
      end while (packg() == prev);
      run_case($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
